// File: rtl/gray_pkg.sv
// Shared Gray-code helpers: widest supported code and the conversion and
// step-check functions used by the converter and by encoders/benches.
package gray_pkg;

  localparam int GRAY_MAX_WID = 64;

  // Prefix XOR from the MSB. Narrower codes are passed zero-extended, and
  // the zero upper bits leave the result unchanged.
  function automatic logic [GRAY_MAX_WID-1:0] gray_to_bin(
    input logic [GRAY_MAX_WID-1:0] g
  );
    logic [GRAY_MAX_WID-1:0] b;
    b[GRAY_MAX_WID-1] = g[GRAY_MAX_WID-1];
    for (int i = GRAY_MAX_WID - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to reflected Gray code.
  function automatic logic [GRAY_MAX_WID-1:0] bin_to_gray(
    input logic [GRAY_MAX_WID-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // True when at most one bit is set. Clearing the lowest set bit leaves
  // zero exactly in that case.
  function automatic logic onehot_or_zero(
    input logic [GRAY_MAX_WID-1:0] x
  );
    return (x & (x - GRAY_MAX_WID'(1))) == '0;
  endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Purely combinational Gray-to-binary conversion of DATA_WID bits.
module gray2bin_comb
  import gray_pkg::*;
#(
  parameter int DATA_WID = 4
) (
  input  logic [DATA_WID-1:0] Gray,
  output logic [DATA_WID-1:0] Bin
);

  logic [GRAY_MAX_WID-1:0] w_gray_ext;
  logic [GRAY_MAX_WID-1:0] w_bin_ext;

  // Widen the input so the shared function can be used at any width.
  always_comb begin
    w_gray_ext = GRAY_MAX_WID'(Gray);
    w_bin_ext  = gray_to_bin(w_gray_ext);
    Bin        = DATA_WID'(w_bin_ext);
  end

endmodule

// File: rtl/gray2bin.sv
// Gray-to-binary converter with a registered output and a step checker that
// flags accepted inputs changing more than one bit from the previous one.
module gray2bin
  import gray_pkg::*;
#(
  parameter int DATA_WID = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_WID-1:0] Gray,
  input  logic                gray_vld,
  output logic [DATA_WID-1:0] Bin,
  output logic                bin_vld,
  output logic                step_err
);

  logic [DATA_WID-1:0] w_bin;
  logic [DATA_WID-1:0] w_diff;
  logic                w_step_bad;

  logic [DATA_WID-1:0] r_bin;
  logic                r_bin_vld;
  logic                r_step_err;
  logic [DATA_WID-1:0] r_last_gray;
  logic                r_first_seen;

  gray2bin_comb #(
    .DATA_WID (DATA_WID)
  ) u_conv (
    .Gray (Gray),
    .Bin  (w_bin)
  );

  // Step check: more than one differing bit against the last accepted code.
  always_comb begin
    w_diff     = Gray ^ r_last_gray;
    w_step_bad = !onehot_or_zero(GRAY_MAX_WID'(w_diff));
  end

  // Output register, last-Gray register and first-sample flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin        <= '0;
      r_bin_vld    <= 1'b0;
      r_step_err   <= 1'b0;
      r_last_gray  <= '0;
      r_first_seen <= 1'b0;
    end else begin
      r_bin_vld  <= gray_vld;
      r_step_err <= gray_vld && r_first_seen && w_step_bad;
      if (gray_vld) begin
        r_bin        <= w_bin;
        r_last_gray  <= Gray;
        r_first_seen <= 1'b1;
      end
    end
  end

  assign Bin      = r_bin;
  assign bin_vld  = r_bin_vld;
  assign step_err = r_step_err;

endmodule

// File: tb/tb_gray2bin.sv
// Self-checking bench for gray2bin (DATA_WID = 4) against a search-based
// reference model of the Gray code.
module tb_gray2bin;
  import gray_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] Gray;
  logic         gray_vld;
  logic [W-1:0] Bin;
  logic         bin_vld;
  logic         step_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_bin;
  int m_vld;
  int m_err;
  int m_last;
  int m_first;

  gray2bin #(
    .DATA_WID (W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Gray     (Gray),
    .gray_vld (gray_vld),
    .Bin      (Bin),
    .bin_vld  (bin_vld),
    .step_err (step_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Binary value whose Gray code is g, found by searching the code table.
  function automatic int gray_inv(input int g);
    for (int k = 0; k < (1 << W); k++) begin
      if ((k ^ (k >> 1)) == g) return k;
    end
    return -1;
  endfunction

  function automatic int popcnt(input int x);
    int c = 0;
    for (int i = 0; i < W; i++) c += (x >> i) & 1;
    return c;
  endfunction

  task automatic model_reset();
    m_bin = 0; m_vld = 0; m_err = 0; m_last = 0; m_first = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".bin"}, 64'(Bin), 64'(m_bin));
    chk({tag, ".vld"}, 64'(bin_vld), 64'(m_vld));
    chk({tag, ".err"}, 64'(step_err), 64'(m_err));
  endtask

  // Drive one cycle (called in the low phase), update the model at the
  // rising edge, compare in the next low phase.
  task automatic cycle(input string tag, input logic v, input logic [W-1:0] g);
    gray_vld = v;
    Gray     = g;
    @(posedge clk);
    if (v) begin
      m_bin   = gray_inv(int'(g));
      m_err   = (m_first != 0 && popcnt(int'(g) ^ m_last) > 1) ? 1 : 0;
      m_last  = int'(g);
      m_first = 1;
      m_vld   = 1;
    end else begin
      m_vld = 0;
      m_err = 0;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    @(posedge clk);
    @(negedge clk);
    check_outputs("rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] g;
    logic [W-1:0] nxt;
    rst_n    = 1'b0;
    gray_vld = 1'b0;
    Gray     = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("rst_init");
    rst_n = 1'b1;

    // Put non-zero values on the outputs, then reset with active inputs
    cycle("pre_rst", 1'b1, 4'b1111);
    chk("pre_rst.bin_const", 64'(Bin), 64'hA);
    Gray     = 4'b1111;
    gray_vld = 1'b1;
    pulse_reset();

    // Exhaustive sweep including the 1000 -> 0000 wrap
    for (int k = 0; k < 16; k++) begin
      g = W'(bin_to_gray(64'(k)));
      cycle("sweep", 1'b1, g);
      chk("sweep.bin_k", 64'(Bin), 64'(k));
    end
    cycle("wrap", 1'b1, 4'b0000);
    chk("wrap.err", 64'(step_err), 64'd0);

    // Spot values
    cycle("spot0010", 1'b1, 4'b0010); chk("spot0010.c", 64'(Bin), 64'b0011);
    cycle("spot0100", 1'b1, 4'b0100); chk("spot0100.c", 64'(Bin), 64'b0111);
    cycle("spot1000", 1'b1, 4'b1000); chk("spot1000.c", 64'(Bin), 64'b1111);
    cycle("spot1111", 1'b1, 4'b1111); chk("spot1111.c", 64'(Bin), 64'b1010);
    cycle("spot0011", 1'b1, 4'b0011); chk("spot0011.c", 64'(Bin), 64'b0010);

    // Step error for one cycle only
    cycle("step_a", 1'b1, 4'b0000);
    cycle("step_b", 1'b1, 4'b0011);
    chk("step_b.err1", 64'(step_err), 64'd1);
    chk("step_b.bin",  64'(Bin), 64'b0010);
    cycle("step_c", 1'b1, 4'b0001);
    chk("step_c.err0", 64'(step_err), 64'd0);

    // Valid gating; the gap keeps the last accepted code (0001)
    for (int i = 0; i < 4; i++) begin
      cycle("gap", 1'b0, W'($urandom));
      chk("gap.bin_hold", 64'(Bin), 64'b0001);
    end
    cycle("gap_after", 1'b1, 4'b0111);
    chk("gap_after.err1", 64'(step_err), 64'd1);

    // Reset mid-stream
    cycle("mid_a", 1'b1, 4'b0101);
    Gray     = 4'b0101;
    gray_vld = 1'b0;
    pulse_reset();
    cycle("mid_b", 1'b1, 4'b1010);
    chk("mid_b.err0", 64'(step_err), 64'd0);
    chk("mid_b.bin",  64'(Bin), 64'b1100);

    // Randomised traffic, biased toward legal single-bit steps
    g = 4'b1010;
    for (int i = 0; i < 300; i++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       nxt = W'($urandom);
        1:       nxt = g;
        default: nxt = g ^ W'(1 << $urandom_range(0, W - 1));
      endcase
      cycle("rand", v, nxt);
      if (v) g = nxt;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gray2bin.md
# gray2bin

Parameterised Gray-code to binary converter with a registered output stage. It sits on the receive side of clock-domain-crossing pointer paths, for example FIFO read and write pointers. There it turns a synchronised Gray-coded count back into a binary value for arithmetic. A Gray step checker flags input updates that change more than one bit, which indicates a CDC or encoding fault.

## Interface
- `DATA_WID`, default 4: width of the Gray input and the binary output; legal range 1..64.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `Gray` input, `DATA_WID` bits: Gray-coded value to convert.
- `gray_vld` input, 1 bit: `Gray` is valid this cycle.
- `Bin` output, `DATA_WID` bits: registered binary equivalent of the last valid `Gray`.
- `bin_vld` output, 1 bit: `Bin` was updated on the previous edge; a 1-cycle pulse per accepted input.
- `step_err` output, 1 bit: registered; set for one cycle when an accepted input differs from the previously accepted input in more than one bit.

## Operation
- Conversion, combinational (prefix XOR from the MSB):
  - `Bin[DATA_WID-1] = Gray[DATA_WID-1]`.
  - `Bin[i] = Bin[i+1] ^ Gray[i]` for i = `DATA_WID-2` down to 0.
  - Equivalently, `Bin[i]` is the XOR of `Gray[DATA_WID-1:i]`.
- Capture: on a rising edge with `gray_vld`=1, the `Bin` register loads the converted value and `bin_vld` goes to 1.
- Hold: on a rising edge with `gray_vld`=0, `Bin` holds its value and `bin_vld` goes to 0.
- Last-Gray register: stores every accepted `Gray`. A first-sample flag is cleared by reset and set after the first accepted input.
- Step check on each accepted input, once the first-sample flag is set:
  - Compute the popcount of (`Gray` XOR last Gray).
  - `step_err` = 1 if the popcount is greater than 1; otherwise 0.
  - Popcount 0 (a repeated value) is legal.
- The first accepted input after reset never raises `step_err`.
- No backpressure: every input with `gray_vld` set is accepted.
- `DATA_WID`=1: `Bin` equals `Gray`, and `step_err` can never assert.

## Timing
- Reset (`rst_n`=0, asynchronous): `Bin`=0, `bin_vld`=0, `step_err`=0, last Gray = 0, first-sample flag cleared. All take effect immediately, without waiting for a clock edge.
- Reset deassertion should be synchronised externally. The first edge after release behaves as a normal cycle.
- Latency: one cycle from `Gray`/`gray_vld` sampled at edge N to `Bin`/`bin_vld`/`step_err` visible after edge N.
- Throughput: one conversion per cycle; back-to-back valid inputs give continuous `bin_vld`=1.
- `step_err` is aligned with the `bin_vld` of the offending sample, and is 0 whenever `bin_vld` is 0.
- Reset mid-stream: results in flight are discarded, and the next accepted input is treated as the first sample.
- Wrap-around from the top Gray code back to 0 (for 4 bits, 1000 to 0000) is a single-bit change and therefore legal.

## Structure
- Shared package `gray_pkg`:
  - Constant `GRAY_MAX_WID` = 64.
  - Function `gray_to_bin`, the prefix XOR.
  - Function `bin_to_gray`, `b ^ (b >> 1)`, for bench and encoder reuse.
  - Function `onehot_or_zero`, the step check.
- Sub-module `gray2bin_comb`: purely combinational conversion, parameterised by `DATA_WID`. The top adds the valid pipeline, the last-Gray register and the step checker.

## Test plan
- Reset: drive `rst_n`=0 with `Gray`=1111 and `gray_vld`=1 -> `Bin`=0000, `bin_vld`=0, `step_err`=0 immediately with no clock edge; all hold until release.
- Exhaustive sweep, `DATA_WID`=4: drive `Gray` = `bin_to_gray(k)` for k = 0..15, valid every cycle -> `Bin`=k one cycle later and `step_err`=0 throughout, including the 1000 to 0000 wrap.
- Spot values: `Gray` 0010 -> 0011; 0100 -> 0111; 1000 -> 1111; 1111 -> 1010; 0011 -> 0010.
- Step error: accept 0000, then 0011 -> `Bin`=0010 with `step_err`=1 in that cycle only. A following input of 0001 -> `step_err`=0.
- Valid gating: hold `gray_vld`=0 while `Gray` toggles -> `Bin` unchanged and `bin_vld`=0. A gap between valid samples does not reset the step check.
- Reset mid-stream: accept 0101, assert then release reset, accept 1010 -> `step_err`=0 (first sample) and `Bin`=1100.
